async_fifo_flags: RTL and testbench

Second-generation dual-clock FIFO for crossing byte/word streams between unrelated clock domains. It adds the following over the first-generation FIFO:
- parametrised depth, width and synchronizer length;
- registered full/empty flags;
- programmable almost-full/almost-empty thresholds;
- fill-level outputs in each domain;
- overflow/underflow pulses;
- a selectable first-word-fall-through read mode.

It sits between any producer on `wr_clk` and consumer on `rd_clk`.

---
 rtl/async_fifo_pkg.sv | 29 ++
 rtl/fifo_sync_chain.sv | 30 +++
 rtl/async_fifo_flags.sv | 162 ++++++++++++++++
 tb/tb_async_fifo_flags.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/async_fifo_pkg.sv
// Shared constants and gray-code helpers for the dual-clock FIFO.
package async_fifo_pkg;

    localparam int DEF_DATA_W      = 8;
    localparam int DEF_ADDR_W      = 4;
    localparam int DEF_AFULL_TH    = 12;
    localparam int DEF_AEMPTY_TH   = 2;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_FWFT        = 0;

    // Widest pointer the helpers handle. Callers zero-extend into this width
    // and cast the result back. Zero upper bits map to zero upper bits in
    // both directions, so the conversion is correct for any width up to 32.
    localparam int MAX_PTR_W = 32;

    function automatic logic [MAX_PTR_W-1:0] bin2gray(input logic [MAX_PTR_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [MAX_PTR_W-1:0] gray2bin(input logic [MAX_PTR_W-1:0] gray);
        logic [MAX_PTR_W-1:0] bin;
        bin[MAX_PTR_W-1] = gray[MAX_PTR_W-1];
        for (int i = MAX_PTR_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_sync_chain.sv
// Multi-flop synchronizer for a gray-coded pointer entering a new clock domain.
module fifo_sync_chain #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [STAGES];

    // Shift the incoming pointer through STAGES flops; all stages clear on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/async_fifo_flags.sv
// Dual-clock FIFO with registered full/empty, almost-full/almost-empty,
// per-domain fill levels, overflow/underflow pulses and optional FWFT read.
//
// Handshake: a write is taken on a wr_clk edge where wr_en=1 and wr_full=0;
// a read is taken on a rd_clk edge where rd_en=1 and rd_empty=0. wr_full and
// rd_empty act as the inverse of ready; requests against them are dropped and
// reported by wr_overflow / rd_underflow for one cycle.
module async_fifo_flags
    import async_fifo_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int AFULL_TH    = DEF_AFULL_TH,
    parameter int AEMPTY_TH   = DEF_AEMPTY_TH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int FWFT        = DEF_FWFT
) (
    input  logic              wr_clk,
    input  logic              w_rst,
    input  logic              rd_clk,
    input  logic              r_rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_full,
    output logic              wr_afull,
    output logic [ADDR_W:0]   wr_level,
    output logic              wr_overflow,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_empty,
    output logic              rd_aempty,
    output logic [ADDR_W:0]   rd_level,
    output logic              rd_underflow
);

    localparam int PTR_W = ADDR_W + 1;
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [PTR_W-1:0] AFULL_V  = PTR_W'(AFULL_TH);
    localparam logic [PTR_W-1:0] AEMPTY_V = PTR_W'(AEMPTY_TH);

    logic [DATA_W-1:0] mem [DEPTH];

    // write domain
    logic             wr_accept;
    logic [PTR_W-1:0] wbin, wgray, wbin_next, wgray_next;
    logic [PTR_W-1:0] rq_gray, rq_bin, wlevel_next, full_gray;

    // read domain
    logic             rd_accept;
    logic [PTR_W-1:0] rbin, rgray, rbin_next, rgray_next;
    logic [PTR_W-1:0] wq_gray, wq_bin, rlevel_next;

    // Read pointer into the write domain, write pointer into the read domain.
    fifo_sync_chain #(.WIDTH(PTR_W), .STAGES(SYNC_STAGES)) u_rptr_sync (
        .clk   (wr_clk),
        .rst_n (w_rst),
        .d     (rgray),
        .q     (rq_gray)
    );

    fifo_sync_chain #(.WIDTH(PTR_W), .STAGES(SYNC_STAGES)) u_wptr_sync (
        .clk   (rd_clk),
        .rst_n (r_rst),
        .d     (wgray),
        .q     (wq_gray)
    );

    // Write-side next-state pointer and the occupancy it implies.
    always_comb begin
        wr_accept   = wr_en && !wr_full;
        wbin_next   = wbin + PTR_W'(wr_accept);
        wgray_next  = PTR_W'(bin2gray(MAX_PTR_W'(wbin_next)));
        rq_bin      = PTR_W'(gray2bin(MAX_PTR_W'(rq_gray)));
        wlevel_next = wbin_next - rq_bin;
        // Full when the write pointer is exactly one lap ahead of the read pointer.
        full_gray   = {~rq_gray[PTR_W-1:PTR_W-2], rq_gray[PTR_W-3:0]};
    end

    // Write-side pointers and registered flags.
    always_ff @(posedge wr_clk or negedge w_rst) begin
        if (!w_rst) begin
            wbin        <= '0;
            wgray       <= '0;
            wr_full     <= 1'b0;
            wr_afull    <= 1'b0;
            wr_level    <= '0;
            wr_overflow <= 1'b0;
        end else begin
            wbin        <= wbin_next;
            wgray       <= wgray_next;
            wr_full     <= (wgray_next == full_gray);
            wr_afull    <= (wlevel_next >= AFULL_V);
            wr_level    <= wlevel_next;
            wr_overflow <= wr_en && wr_full;
        end
    end

    // Storage array: written on wr_clk, never reset.
    always_ff @(posedge wr_clk) begin
        if (wr_accept) begin
            mem[wbin[ADDR_W-1:0]] <= wr_data;
        end
    end

    // Read-side next-state pointer and the occupancy it implies.
    always_comb begin
        rd_accept   = rd_en && !rd_empty;
        rbin_next   = rbin + PTR_W'(rd_accept);
        rgray_next  = PTR_W'(bin2gray(MAX_PTR_W'(rbin_next)));
        wq_bin      = PTR_W'(gray2bin(MAX_PTR_W'(wq_gray)));
        rlevel_next = wq_bin - rbin_next;
    end

    // Read-side pointers and registered flags.
    always_ff @(posedge rd_clk or negedge r_rst) begin
        if (!r_rst) begin
            rbin         <= '0;
            rgray        <= '0;
            rd_empty     <= 1'b1;
            rd_aempty    <= 1'b1;
            rd_level     <= '0;
            rd_underflow <= 1'b0;
        end else begin
            rbin         <= rbin_next;
            rgray        <= rgray_next;
            rd_empty     <= (rgray_next == wq_gray);
            rd_aempty    <= (rlevel_next <= AEMPTY_V);
            rd_level     <= rlevel_next;
            rd_underflow <= rd_en && rd_empty;
        end
    end

    generate
        if (FWFT == 0) begin : g_std_read
            logic [DATA_W-1:0] rd_data_q;
            logic              rd_valid_q;

            // Registered read port: data lands one cycle after the pop and is held.
            always_ff @(posedge rd_clk or negedge r_rst) begin
                if (!r_rst) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_accept;
                    if (rd_accept) begin
                        rd_data_q <= mem[rbin[ADDR_W-1:0]];
                    end
                end
            end

            assign rd_data  = rd_data_q;
            assign rd_valid = rd_valid_q;
        end else begin : g_fwft_read
            // Head word is presented directly; forced to zero while empty so the
            // output never shows uninitialised storage.
            assign rd_data  = rd_empty ? '0 : mem[rbin[ADDR_W-1:0]];
            assign rd_valid = !rd_empty;
        end
    endgenerate

endmodule

// File: tb/tb_async_fifo_flags.sv
// Bench for async_fifo_flags: directed fill/drain, underflow, FWFT and reset
// scenarios plus a randomized two-clock stream against a queue model.
module tb_async_fifo_flags;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int AF_TH  = 12;
    localparam int AE_TH  = 2;
    localparam int N_RAND = 200;

    // ---------------- clock / reset ----------------
    logic wr_clk = 1'b0;
    logic rd_clk = 1'b0;
    logic w_rst  = 1'b0;
    logic r_rst  = 1'b0;

    always #5ns   wr_clk = ~wr_clk;
    always #3.5ns rd_clk = ~rd_clk;

    // ---------------- standard-read DUT ----------------
    logic              wr_en = 1'b0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              rd_en = 1'b0;
    logic              wr_full, wr_afull, wr_overflow;
    logic [ADDR_W:0]   wr_level, rd_level;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid, rd_empty, rd_aempty, rd_underflow;

    async_fifo_flags #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .AFULL_TH(AF_TH),
                       .AEMPTY_TH(AE_TH), .SYNC_STAGES(2), .FWFT(0)) dut (
        .wr_clk       (wr_clk),
        .w_rst        (w_rst),
        .rd_clk       (rd_clk),
        .r_rst        (r_rst),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .wr_full      (wr_full),
        .wr_afull     (wr_afull),
        .wr_level     (wr_level),
        .wr_overflow  (wr_overflow),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .rd_empty     (rd_empty),
        .rd_aempty    (rd_aempty),
        .rd_level     (rd_level),
        .rd_underflow (rd_underflow)
    );

    // ---------------- FWFT DUT ----------------
    logic              ft_wr_en = 1'b0;
    logic [DATA_W-1:0] ft_wr_data = '0;
    logic              ft_rd_en = 1'b0;
    logic              ft_wr_full, ft_wr_afull, ft_wr_overflow;
    logic [ADDR_W:0]   ft_wr_level, ft_rd_level;
    logic [DATA_W-1:0] ft_rd_data;
    logic              ft_rd_valid, ft_rd_empty, ft_rd_aempty, ft_rd_underflow;

    async_fifo_flags #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .AFULL_TH(AF_TH),
                       .AEMPTY_TH(AE_TH), .SYNC_STAGES(2), .FWFT(1)) dut_ft (
        .wr_clk       (wr_clk),
        .w_rst        (w_rst),
        .rd_clk       (rd_clk),
        .r_rst        (r_rst),
        .wr_en        (ft_wr_en),
        .wr_data      (ft_wr_data),
        .wr_full      (ft_wr_full),
        .wr_afull     (ft_wr_afull),
        .wr_level     (ft_wr_level),
        .wr_overflow  (ft_wr_overflow),
        .rd_en        (ft_rd_en),
        .rd_data      (ft_rd_data),
        .rd_valid     (ft_rd_valid),
        .rd_empty     (ft_rd_empty),
        .rd_aempty    (ft_rd_aempty),
        .rd_level     (ft_rd_level),
        .rd_underflow (ft_rd_underflow)
    );

    // ---------------- scoreboard ----------------
    logic [DATA_W-1:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_wr_full"},       wr_full, 0);
        check_eq({tag, "_wr_afull"},      wr_afull, 0);
        check_eq({tag, "_wr_level"},      wr_level, 0);
        check_eq({tag, "_wr_overflow"},   wr_overflow, 0);
        check_eq({tag, "_rd_empty"},      rd_empty, 1);
        check_eq({tag, "_rd_aempty"},     rd_aempty, 1);
        check_eq({tag, "_rd_valid"},      rd_valid, 0);
        check_eq({tag, "_rd_underflow"},  rd_underflow, 0);
        check_eq({tag, "_rd_level"},      rd_level, 0);
        check_eq({tag, "_rd_data"},       rd_data, 0);
        check_eq({tag, "_ft_wr_full"},    ft_wr_full, 0);
        check_eq({tag, "_ft_wr_afull"},   ft_wr_afull, 0);
        check_eq({tag, "_ft_wr_level"},   ft_wr_level, 0);
        check_eq({tag, "_ft_wr_ovf"},     ft_wr_overflow, 0);
        check_eq({tag, "_ft_rd_empty"},   ft_rd_empty, 1);
        check_eq({tag, "_ft_rd_aempty"},  ft_rd_aempty, 1);
        check_eq({tag, "_ft_rd_valid"},   ft_rd_valid, 0);
        check_eq({tag, "_ft_rd_unf"},     ft_rd_underflow, 0);
        check_eq({tag, "_ft_rd_level"},   ft_rd_level, 0);
        check_eq({tag, "_ft_rd_data"},    ft_rd_data, 0);
    endtask

    // ---------------- drivers ----------------
    task automatic wr_word(input logic [DATA_W-1:0] d);
        @(negedge wr_clk);
        wr_en   = 1'b1;
        wr_data = d;
        exp_q.push_back(d);
        @(negedge wr_clk);
        wr_en = 1'b0;
    endtask

    // One pop on the standard DUT; the word must be valid in the next cycle.
    task automatic rd_word(input string tag);
        logic [DATA_W-1:0] exp;
        @(negedge rd_clk);
        rd_en = 1'b1;
        @(negedge rd_clk);
        rd_en = 1'b0;
        check_eq({tag, "_valid"}, rd_valid, 1);
        if (exp_q.size() == 0) begin
            check_eq({tag, "_model_empty"}, 1, 0);
        end else begin
            exp = exp_q.pop_front();
            check_eq({tag, "_data"}, rd_data, exp);
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached (errors=%0d)", n_errors);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int  edges;
        bit  seen;
        int  sent, got, cyc, ovf_seen, unf_seen;

        // reset
        repeat (3) @(negedge wr_clk);
        w_rst = 1'b1;
        r_rst = 1'b1;
        repeat (2) @(negedge wr_clk);
        check_reset_state("rst");

        // FWFT: word appears without rd_en, then one pop empties it
        @(negedge wr_clk);
        ft_wr_en   = 1'b1;
        ft_wr_data = 8'hA5;
        @(posedge wr_clk);
        fork
            begin
                @(negedge wr_clk);
                ft_wr_en = 1'b0;
            end
        join_none
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 6) begin
            @(posedge rd_clk);
            edges++;
            @(negedge rd_clk);
            if (ft_rd_valid) seen = 1'b1;
        end
        check_eq("ft_valid_within_3", (seen && edges <= 3), 1);
        check_eq("ft_head_data", ft_rd_data, 8'hA5);
        check_eq("ft_not_empty", ft_rd_empty, 0);
        ft_rd_en = 1'b1;
        @(negedge rd_clk);
        ft_rd_en = 1'b0;
        check_eq("ft_pop_valid", ft_rd_valid, 0);
        check_eq("ft_pop_empty", ft_rd_empty, 1);

        // fill: 16 back-to-back writes, read side idle
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge wr_clk);
            check_eq("fill_level", wr_level, i);
            check_eq("fill_afull", wr_afull, (i >= AF_TH));
            check_eq("fill_full", wr_full, 0);
            wr_en   = 1'b1;
            wr_data = DATA_W'(i);
            exp_q.push_back(DATA_W'(i));
        end
        @(negedge wr_clk);
        check_eq("full_after_16", wr_full, 1);
        check_eq("level_after_16", wr_level, DEPTH);
        check_eq("afull_after_16", wr_afull, 1);
        wr_data = 8'hFF;
        @(negedge wr_clk);
        wr_en = 1'b0;
        check_eq("ovf_pulse", wr_overflow, 1);
        check_eq("ovf_level", wr_level, DEPTH);
        check_eq("ovf_full", wr_full, 1);
        @(negedge wr_clk);
        check_eq("ovf_one_cycle", wr_overflow, 0);

        // drain
        repeat (6) @(negedge rd_clk);
        check_eq("drain_rd_level", rd_level, DEPTH);
        check_eq("drain_not_empty", rd_empty, 0);
        check_eq("drain_not_aempty", rd_aempty, 0);
        for (int i = 0; i < DEPTH; i++) begin
            rd_word("drain");
            check_eq("drain_aempty", rd_aempty, ((DEPTH - 1 - i) <= AE_TH));
            check_eq("drain_level", rd_level, DEPTH - 1 - i);
        end
        check_eq("drain_empty", rd_empty, 1);
        repeat (6) @(negedge wr_clk);
        check_eq("drain_wr_full_clear", wr_full, 0);
        check_eq("drain_wr_level", wr_level, 0);

        // underflow
        @(negedge rd_clk);
        rd_en = 1'b1;
        @(negedge rd_clk);
        rd_en = 1'b0;
        check_eq("unf_pulse", rd_underflow, 1);
        check_eq("unf_valid", rd_valid, 0);
        check_eq("unf_level", rd_level, 0);
        @(negedge rd_clk);
        check_eq("unf_one_cycle", rd_underflow, 0);
        check_eq("unf_valid_after", rd_valid, 0);

        // randomized stream across unrelated clocks
        sent = 0;
        got = 0;
        cyc = 0;
        ovf_seen = 0;
        unf_seen = 0;
        fork
            begin
                while (sent < N_RAND) begin
                    @(negedge wr_clk);
                    if (wr_overflow) ovf_seen++;
                    wr_en = 1'b0;
                    if (!wr_full && $urandom_range(0, 99) < 60) begin
                        wr_en   = 1'b1;
                        wr_data = DATA_W'(sent);
                        exp_q.push_back(DATA_W'(sent));
                        sent++;
                    end
                end
                @(negedge wr_clk);
                wr_en = 1'b0;
            end
            begin
                while (got < N_RAND && cyc < 5000) begin
                    @(negedge rd_clk);
                    cyc++;
                    if (rd_underflow) unf_seen++;
                    if (rd_valid) begin
                        if (exp_q.size() == 0) begin
                            check_eq("rand_model_empty", 1, 0);
                        end else begin
                            check_eq("rand_data", rd_data, exp_q.pop_front());
                        end
                        got++;
                    end
                    rd_en = !rd_empty && ($urandom_range(0, 99) < 50);
                end
                rd_en = 1'b0;
            end
        join
        check_eq("rand_rx_count", got, N_RAND);
        check_eq("rand_no_overflow", ovf_seen, 0);
        check_eq("rand_no_underflow", unf_seen, 0);
        check_eq("rand_model_drained", exp_q.size(), 0);

        // reset mid-operation
        for (int i = 0; i < 9; i++) begin
            wr_word(DATA_W'(8'h40 + i));
        end
        repeat (6) @(negedge rd_clk);
        check_eq("mid_wr_level", wr_level, 9);
        check_eq("mid_rd_level", rd_level, 9);
        @(negedge wr_clk);
        w_rst = 1'b0;
        r_rst = 1'b0;
        #20ns;
        check_reset_state("midrst");
        @(negedge wr_clk);
        w_rst = 1'b1;
        r_rst = 1'b1;
        exp_q.delete();
        repeat (2) @(negedge wr_clk);
        check_reset_state("postrst");
        wr_word(8'h3C);
        repeat (6) @(negedge rd_clk);
        check_eq("post_rd_level", rd_level, 1);
        rd_word("post");
        check_eq("post_empty", rd_empty, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
